// File: rtl/sample_ring_buffer.sv
// Sample ring buffer: FIFO pop or delay-tap peek, 1-cycle registered read, all updates gated by operational_clock.
// Backpressure: wr_ready = !full; refused writes/pops raise sticky overflow/underflow until clear_flags.
module sample_ring_buffer #(
   parameter int DATA_WIDTH    = 16,
   parameter int DEPTH         = 16,
   parameter int ADDRESS_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     operational_clock,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     rd_req,
   input  logic                     tap_mode,
   input  logic [ADDRESS_WIDTH-1:0] tap_offset,
   output logic                     rd_valid,
   output logic [DATA_WIDTH-1:0]    data_out,
   input  logic                     output_enable,
   output logic [ADDRESS_WIDTH:0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clear_flags
);

   localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = (ADDRESS_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic [ADDRESS_WIDTH-1:0] wr_ptr;
   logic [ADDRESS_WIDTH-1:0] rd_ptr;
   logic [ADDRESS_WIDTH:0]   count_q;
   logic [ADDRESS_WIDTH:0]   count_next;
   logic [DATA_WIDTH-1:0]    data_q;
   logic                     rd_valid_q;
   logic                     overflow_q;
   logic                     underflow_q;

   logic                     wr_fire;
   logic                     pop_fire;
   logic                     peek_fire;
   logic                     overflow_set;
   logic                     underflow_set;
   logic [ADDRESS_WIDTH-1:0] tap_addr;
   logic [ADDRESS_WIDTH-1:0] rd_addr;

   assign full      = (count_q == FULL_COUNT);
   assign empty     = (count_q == '0);
   assign wr_ready  = ~full;
   assign count     = count_q;
   assign rd_valid  = rd_valid_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign data_out  = output_enable ? data_q : {DATA_WIDTH{1'bz}};

   // Full refuses the write even when a pop frees a slot in the same cycle.
   assign wr_fire       = operational_clock & wr_valid & ~full;
   assign overflow_set  = operational_clock & wr_valid & full;
   assign pop_fire      = operational_clock & rd_req & ~tap_mode & ~empty;
   assign underflow_set = operational_clock & rd_req & ~tap_mode & empty;
   assign peek_fire     = operational_clock & rd_req & tap_mode;

   // Offset 0 is the most recently written sample.
   assign tap_addr = wr_ptr - ADDRESS_WIDTH'(1) - tap_offset;
   assign rd_addr  = tap_mode ? tap_addr : rd_ptr;

   always_comb begin
      count_next = count_q;
      case ({wr_fire, pop_fire})
         2'b10:   count_next = count_q + 1'b1;
         2'b01:   count_next = count_q - 1'b1;
         default: count_next = count_q;
      endcase
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         data_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= pop_fire | peek_fire;
         count_q    <= count_next;
         if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Non-blocking read of mem gives read-before-write on a same-cycle collision.
         if (pop_fire | peek_fire) begin
            data_q <= mem[rd_addr];
         end
      end
   end

   // A new error in the same cycle wins over clear_flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_set  | (overflow_q  & ~clear_flags);
         underflow_q <= underflow_set | (underflow_q & ~clear_flags);
      end
   end

endmodule

// File: tb/tb_sample_ring_buffer.sv
// Directed bench for sample_ring_buffer with hand-computed expectations.
module tb_sample_ring_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        operational_clock;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] data_in;
   logic        rd_req;
   logic        tap_mode;
   logic [3:0]  tap_offset;
   logic        rd_valid;
   wire  [15:0] data_out;
   logic        output_enable;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        underflow;
   logic        clear_flags;

   int errors = 0;
   int checks = 0;

   sample_ring_buffer #(.DATA_WIDTH(16), .DEPTH(16), .ADDRESS_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .operational_clock(operational_clock),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .data_in(data_in),
      .rd_req(rd_req), .tap_mode(tap_mode), .tap_offset(tap_offset),
      .rd_valid(rd_valid), .data_out(data_out), .output_enable(output_enable),
      .count(count), .full(full), .empty(empty),
      .overflow(overflow), .underflow(underflow), .clear_flags(clear_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus, then release the request strobes 1 time unit after the edge.
   task automatic step(input logic wv, input logic [15:0] d, input logic rr,
                       input logic tm, input logic [3:0] off, input logic clr);
      wr_valid    = wv;
      data_in     = d;
      rd_req      = rr;
      tap_mode    = tm;
      tap_offset  = off;
      clear_flags = clr;
      @(posedge clk);
      #1;
      wr_valid    = 1'b0;
      rd_req      = 1'b0;
      clear_flags = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; operational_clock = 1'b1; output_enable = 1'b1;
      wr_valid = 1'b0; data_in = '0; rd_req = 1'b0; tap_mode = 1'b0;
      tap_offset = '0; clear_flags = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_flags", {overflow, underflow}, 0);
      chk("rst_data_out", data_out, 0);
      rst_n = 1'b1;

      // Basic FIFO order, wr_ptr/rd_ptr 0..3
      for (int i = 1; i <= 3; i++) step(1, 16'(i), 0, 0, 0, 0);
      chk("fifo_count3", count, 3);
      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 1, 0, 0, 0);
         chk("fifo_pop_valid", rd_valid, 1);
         chk("fifo_pop_data", data_out, 32'(i));
      end
      chk("fifo_count0", count, 0);
      chk("fifo_empty", empty, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("fifo_valid_drop", rd_valid, 0);

      // Fill: 0x100..0x10F at addresses 3..15,0..2
      for (int i = 0; i < 16; i++) step(1, 16'(16'h100 + i), 0, 0, 0, 0);
      chk("fill_full", full, 1);
      chk("fill_wr_ready", wr_ready, 0);
      chk("fill_count", count, 16);
      step(1, 16'hAAAA, 1, 0, 0, 0);
      chk("ovf_flag", overflow, 1);
      chk("ovf_pop_data", data_out, 32'h100);
      chk("ovf_count", count, 15);
      step(0, 0, 0, 0, 0, 1);
      chk("ovf_clear", overflow, 0);
      for (int i = 1; i < 16; i++) begin
         step(0, 0, 1, 0, 0, 0);
         chk("drain_data", data_out, 32'(16'h100 + i));
      end
      chk("drain_count", count, 0);

      // Pop from empty with concurrent write of 5 (address 3)
      step(1, 16'd5, 1, 0, 0, 0);
      chk("udf_flag", underflow, 1);
      chk("udf_no_valid", rd_valid, 0);
      chk("udf_count", count, 1);
      step(0, 0, 1, 0, 0, 0);
      chk("udf_next_pop", data_out, 5);
      chk("udf_next_valid", rd_valid, 1);
      step(0, 0, 1, 0, 0, 1);
      chk("clr_vs_new_err", underflow, 1);
      operational_clock = 1'b0;
      step(0, 0, 0, 0, 0, 1);
      chk("clr_while_disabled", underflow, 0);
      operational_clock = 1'b1;

      // 10..29 at addresses 4..15,0..7 with a pop on each odd value
      for (int k = 10; k <= 29; k++) begin
         step(1, 16'(k), k % 2, 0, 0, 0);
         if (k % 2 == 1) chk("wrap_pop_data", data_out, 32'(10 + (k - 11) / 2));
      end
      chk("wrap_count", count, 10);
      step(0, 0, 1, 1, 4'd0, 0);
      chk("tap0_data", data_out, 29);
      chk("tap0_valid", rd_valid, 1);
      step(0, 0, 1, 1, 4'd3, 0);
      chk("tap3_data", data_out, 26);
      chk("tap_count", count, 10);
      // Peek the slot being written (address 8, old value 14)
      step(1, 16'd30, 1, 1, 4'd15, 0);
      chk("rbw_data", data_out, 14);
      chk("rbw_count", count, 11);

      // Disabled sample clock: requests ignored
      operational_clock = 1'b0;
      step(1, 16'h77, 1, 0, 0, 0);
      chk("gate_rd_valid", rd_valid, 0);
      chk("gate_count", count, 11);
      chk("gate_data_hold", data_out, 14);
      step(0, 0, 1, 1, 4'd0, 0);
      chk("gate_peek_valid", rd_valid, 0);
      operational_clock = 1'b1;
      step(0, 0, 1, 0, 0, 0);
      chk("gate_resume_pop", data_out, 20);
      chk("gate_resume_count", count, 10);

      // Output enable: data_out must stop driving the held value 20
      output_enable = 1'b0;
      #1;
      checks++;
      assert (data_out !== 16'd20)
      else begin
         errors++;
         $error("FAIL oe_hiz observed=%0h expected=zzzz", data_out);
      end
      output_enable = 1'b1;
      #1;
      chk("oe_restore", data_out, 20);

      // Reset asserted while a pop request is pending
      rd_req = 1'b1; tap_mode = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_data", data_out, 0);
      chk("mid_rst_valid", rd_valid, 0);
      chk("mid_rst_status", {empty, full, wr_ready}, 3'b101);
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      rst_n  = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      chk("post_rst_valid", rd_valid, 0);
      chk("post_rst_count", count, 0);
      step(1, 16'h1234, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("post_rst_resume", data_out, 32'h1234);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
